ultrasonic_echo_emulator: RTL
=============================

Name: ultrasonic_echo_emulator

Overview:
Synthesizable model of the ultrasonic sensor at the far end of the trig/echo interface. Detects a valid trigger pulse, waits a fixed burst delay, then drives an echo pulse whose width encodes a programmable target distance (CYCLES_PER_CM clocks per cm at 50 MHz). Used on-board as a loopback target and in simulation to exercise the radar front end without hardware.

Parameters:
CYCLES_PER_CM, 2900, echo-high clocks per cm of target distance
MIN_TRIG_CYCLES, 500, minimum synchronized trig-high width accepted (10 us)
BURST_DELAY, 10000, clocks from trigger acceptance to echo rise (200 us)
MAX_CM, 400, largest in-range target distance
TIMEOUT_CYCLES, 1900000, echo width for out-of-range target (38 ms)
HOLDOFF_CYCLES, 2500, dead time after echo fall before re-arming

Ports:
clk  input  1  50 MHz system clock
rst_n  input  1  asynchronous active-low reset
trig  input  1  trigger from controller, asynchronous to clk
target_cm  input  16  emulated distance in cm, sampled at acceptance
echo  output  1  echo pulse to controller, registered
busy  output  1  high in any state other than IDLE
short_trig  output  1  one-cycle pulse when a trig pulse is rejected as too short
echo_count  output  16  number of echoes emitted, wraps 0xFFFF->0

Behaviour:
- Reset: echo=0, busy=0, short_trig=0, echo_count=0, state=IDLE, all counters 0, synchronizer flops 0. Reset is asynchronous; asserting it mid-echo drops echo immediately.
- trig passes through a 2-flop synchronizer; all edge detection uses the synchronized signal (trig_s) and its delayed copy.
- States: IDLE, TRIG_HIGH, BURST, ECHO, HOLDOFF.
- IDLE: on trig_s rising edge -> TRIG_HIGH, width counter cleared to 1. A trig_s already high on entering IDLE does not arm; a fresh rising edge is required.
- TRIG_HIGH: width counter increments each clock trig_s is high, saturating at 2^16-1. On the cycle trig_s is seen low (acceptance cycle A):
  - width >= MIN_TRIG_CYCLES: sample target_cm. If target_cm==0 or target_cm>MAX_CM, W=TIMEOUT_CYCLES; else W=target_cm*CYCLES_PER_CM, using a 24-bit product with no truncation. Go to BURST.
  - width < MIN_TRIG_CYCLES: short_trig=1 for exactly one cycle, return to IDLE, no echo.
- BURST: counts BURST_DELAY clocks; echo goes high BURST_DELAY+1 clocks after cycle A. Go to ECHO.
- ECHO: echo is high for exactly W clocks. echo_count increments by 1 on the cycle echo falls. Then go to HOLDOFF.
- HOLDOFF: HOLDOFF_CYCLES clocks, echo=0, then IDLE.
- Trig edges in BURST, ECHO or HOLDOFF are ignored, with no short_trig and no queueing.
- Changes to target_cm after cycle A do not affect the echo in flight.
- All counters are 24 bits. W and BURST_DELAY must be >=1; a parameter value of 0 is illegal.

Optional Feature:
ECHO_JITTER_EN: when defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11; reset seed 0xACE1) advances once per accepted trigger. lfsr[7:0] is added to W, giving 0..255 extra clocks, for both in-range and timeout echoes. The first echo after reset uses the seed value, so jitter=0xE1=225 clocks. When not defined, W is exact as above and no LFSR exists.

Test Plan:
1. trig high 500 clk, target_cm=10 -> no short_trig; echo rises BURST_DELAY+1=10001 clk after acceptance, high exactly 29000 clk; echo_count=1; busy returns low 2500 clk after echo fall.
2. trig high 499 clk -> short_trig single-cycle pulse, echo stays 0, echo_count unchanged, busy low within 1 clk.
3. target_cm=400 -> echo width 1160000; target_cm=401 -> width 1900000; target_cm=0 -> width 1900000.
4. Second 500-clk trig issued during ECHO and again during HOLDOFF -> ignored, exactly one echo, echo_count +1 only; target_cm changed mid-echo has no effect on width.
5. rst_n asserted 1000 clk into ECHO -> echo, busy and echo_count 0 immediately; after release, a new valid trig produces a normal echo.
6. With ECHO_JITTER_EN, first echo after reset with target_cm=10 -> width 29225; without the macro -> 29000.

Source files
------------

// File: rtl/ultrasonic_echo_emulator.sv
// ---------------------------------------------------------------------------
// ultrasonic_echo_emulator
//
// Emulates the sensor at the far end of a trig/echo ultrasonic interface.
// It accepts a trigger pulse that is long enough, waits a fixed burst delay,
// and then drives an echo pulse. The echo width encodes the programmed target
// distance. Targets of 0 cm or beyond MAX_CM produce a timeout-width echo.
//
// Ports:
//   clk         in   1   system clock (50 MHz nominal)
//   rst_n       in   1   asynchronous active-low reset
//   trig        in   1   trigger from controller, asynchronous to clk
//   target_cm   in  16   emulated distance in cm, sampled when the trigger
//                        is accepted
//   echo        out  1   echo pulse, registered
//   busy        out  1   high whenever the emulator is not idle
//   short_trig  out  1   one-cycle pulse when a trigger is rejected as too
//                        short
//   echo_count  out 16   number of echoes emitted, wraps 0xFFFF -> 0
//
// Optional feature (compile-time macro ECHO_JITTER_EN):
//   When defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 0xACE1)
//   steps once per accepted trigger. Its low byte is added to the echo width,
//   so each echo gets 0..255 extra clocks.
// ---------------------------------------------------------------------------
module ultrasonic_echo_emulator #(
  parameter int CYCLES_PER_CM   = 2900,
  parameter int MIN_TRIG_CYCLES = 500,
  parameter int BURST_DELAY     = 10000,
  parameter int MAX_CM          = 400,
  parameter int TIMEOUT_CYCLES  = 1900000,
  parameter int HOLDOFF_CYCLES  = 2500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trig,
  input  logic [15:0] target_cm,
  output logic        echo,
  output logic        busy,
  output logic        short_trig,
  output logic [15:0] echo_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG_HIGH,
    S_BURST,
    S_ECHO,
    S_HOLDOFF
  } state_t;

  localparam logic [23:0] CPC        = 24'(CYCLES_PER_CM);
  localparam logic [23:0] MIN_TRIG   = 24'(MIN_TRIG_CYCLES);
  localparam logic [23:0] BURST_LAST = 24'(BURST_DELAY - 1);
  localparam logic [23:0] MAX_DIST   = 24'(MAX_CM);
  localparam logic [23:0] TIMEOUT_W  = 24'(TIMEOUT_CYCLES);
  localparam logic [23:0] HOLD_LAST  = 24'(HOLDOFF_CYCLES - 1);
  localparam logic [23:0] WIDTH_SAT  = 24'h00_FFFF;

  // Synchronizer and edge detection
  logic trig_meta;
  logic trig_s;
  logic trig_d;
  logic trig_rise;

  // Controller state and datapath registers
  state_t      state,      state_nxt;
  logic [23:0] width_cnt,  width_nxt;
  logic [23:0] cnt,        cnt_nxt;
  logic [23:0] echo_w,     echo_w_nxt;
  logic        echo_nxt;
  logic        short_nxt;
  logic [15:0] count_nxt;
  logic        accept;

  // Echo width computed from the live target_cm; it is captured only in the
  // acceptance cycle, so later target changes cannot touch an echo in flight.
  logic [23:0] prod;
  logic        in_range;
  logic [23:0] base_w;
  logic [23:0] sample_w;

  // NOTE: sequential state is always updated with non-blocking assignments so
  // every flop samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_meta <= 1'b0;
      trig_s    <= 1'b0;
      trig_d    <= 1'b0;
    end else begin
      trig_meta <= trig;
      trig_s    <= trig_meta;
      trig_d    <= trig_s;
    end
  end

  assign trig_rise = trig_s & ~trig_d;

  assign prod     = 24'(target_cm) * CPC;
  assign in_range = (target_cm != 16'd0) && (24'(target_cm) <= MAX_DIST);
  assign base_w   = in_range ? prod : TIMEOUT_W;

`ifdef ECHO_JITTER_EN
  logic [15:0] lfsr;
  logic        lfsr_fb;

  assign lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  // The current LFSR value jitters this echo; the step happens afterwards,
  // so the first echo after reset uses the seed.
  assign sample_w = base_w + {16'd0, lfsr[7:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= 16'hACE1;
    end else if (accept) begin
      lfsr <= {lfsr[14:0], lfsr_fb};
    end
  end
`else
  assign sample_w = base_w;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      width_cnt  <= '0;
      cnt        <= '0;
      echo_w     <= '0;
      echo       <= 1'b0;
      short_trig <= 1'b0;
      echo_count <= '0;
    end else begin
      state      <= state_nxt;
      width_cnt  <= width_nxt;
      cnt        <= cnt_nxt;
      echo_w     <= echo_w_nxt;
      echo       <= echo_nxt;
      short_trig <= short_nxt;
      echo_count <= count_nxt;
    end
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_nxt  = state;
    width_nxt  = width_cnt;
    cnt_nxt    = cnt;
    echo_w_nxt = echo_w;
    echo_nxt   = echo;
    short_nxt  = 1'b0;
    count_nxt  = echo_count;
    accept     = 1'b0;

    unique case (state)
      // Only a fresh rising edge arms; a trig that is already high when the
      // holdoff ends produces no edge here and is ignored.
      S_IDLE: begin
        if (trig_rise) begin
          state_nxt = S_TRIG_HIGH;
          width_nxt = 24'd1;
        end
      end

      S_TRIG_HIGH: begin
        if (trig_s) begin
          if (width_cnt < WIDTH_SAT) width_nxt = width_cnt + 24'd1;
        end else if (width_cnt >= MIN_TRIG) begin
          accept     = 1'b1;
          echo_w_nxt = sample_w;
          cnt_nxt    = '0;
          state_nxt  = S_BURST;
        end else begin
          short_nxt = 1'b1;
          state_nxt = S_IDLE;
        end
      end

      // echo is registered, so raising echo_nxt on the last burst cycle puts
      // the rising edge BURST_DELAY+1 clocks after the acceptance cycle.
      S_BURST: begin
        if (cnt == BURST_LAST) begin
          cnt_nxt   = '0;
          echo_nxt  = 1'b1;
          state_nxt = S_ECHO;
        end else begin
          cnt_nxt = cnt + 24'd1;
        end
      end

      S_ECHO: begin
        if (cnt == echo_w - 24'd1) begin
          cnt_nxt   = '0;
          echo_nxt  = 1'b0;
          count_nxt = echo_count + 16'd1;
          state_nxt = (HOLDOFF_CYCLES == 0) ? S_IDLE : S_HOLDOFF;
        end else begin
          cnt_nxt = cnt + 24'd1;
        end
      end

      S_HOLDOFF: begin
        if (cnt == HOLD_LAST) begin
          cnt_nxt   = '0;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt + 24'd1;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

endmodule
